// File: rtl/tta_cpu.sv
// tta_cpu: parametrised transport-triggered CPU. Every instruction is a single
// move "source -> destination". The fetch side is a combinational-read program
// memory. The data side is a valid/ready handshaked memory addressed by p.
//
// Optional build macro: TTA_CPU_SHIFT_OPS_EN adds shift sources 17/18/19
// (a << b, a >> b logical, a >>> b arithmetic). When it is undefined, those
// codes read as zero.
//
// Parameters:
//   WIDTH        data register / ALU width (multiple of 8, >= 16)
//   PC_WIDTH     program counter and pm_address width
//   RESET_VECTOR pc value loaded at reset
//
// Ports:
//   clock        system clock, all state on the rising edge
//   reset        synchronous, active-high
//   pm_address   instruction fetch address (always equals pc)
//   pm_data_in   instruction word, valid in the same cycle
//   dm_req       data-memory request (combinational)
//   dm_we        1 = store, 0 = load; meaningful while dm_req = 1
//   dm_address   data-memory address (equals p)
//   dm_wdata     store data; zero when no store is requested
//   dm_rdata     load data, sampled when dm_req & dm_ready
//   dm_ready     completes the transaction on an edge with dm_req & dm_ready
//   halted       core stopped; only reset restarts it
module tta_cpu #(
    parameter int unsigned         WIDTH        = 16,
    parameter int unsigned         PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] pm_address,
    input  logic [15:0]         pm_data_in,
    output logic                dm_req,
    output logic                dm_we,
    output logic [WIDTH-1:0]    dm_address,
    output logic [WIDTH-1:0]    dm_wdata,
    input  logic [WIDTH-1:0]    dm_rdata,
    input  logic                dm_ready,
    output logic                halted
);

    localparam int unsigned PRE_W = WIDTH - 8;

    // Core states
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Format-1 source codes
    localparam logic [7:0] SRC_ZERO = 8'd0;
    localparam logic [7:0] SRC_A    = 8'd1;
    localparam logic [7:0] SRC_B    = 8'd2;
    localparam logic [7:0] SRC_P    = 8'd3;
    localparam logic [7:0] SRC_PC   = 8'd4;
    localparam logic [7:0] SRC_ADD  = 8'd5;
    localparam logic [7:0] SRC_SUB  = 8'd6;
    localparam logic [7:0] SRC_AND  = 8'd7;
    localparam logic [7:0] SRC_OR   = 8'd8;
    localparam logic [7:0] SRC_XOR  = 8'd9;
    localparam logic [7:0] SRC_LT   = 8'd10;
    localparam logic [7:0] SRC_LE   = 8'd11;
    localparam logic [7:0] SRC_EQ   = 8'd12;
    localparam logic [7:0] SRC_GE   = 8'd13;
    localparam logic [7:0] SRC_GT   = 8'd14;
    localparam logic [7:0] SRC_MEM  = 8'd15;
    localparam logic [7:0] SRC_LR   = 8'd16;
`ifdef TTA_CPU_SHIFT_OPS_EN
    localparam logic [7:0] SRC_SHL  = 8'd17;
    localparam logic [7:0] SRC_SHR  = 8'd18;
    localparam logic [7:0] SRC_SAR  = 8'd19;
    localparam int unsigned SH_W    = $clog2(WIDTH);
`endif

    // Destination codes
    localparam logic [6:0] DST_PFX  = 7'd0;
    localparam logic [6:0] DST_A    = 7'd1;
    localparam logic [6:0] DST_B    = 7'd2;
    localparam logic [6:0] DST_P    = 7'd3;
    localparam logic [6:0] DST_JMP  = 7'd4;
    localparam logic [6:0] DST_JZ   = 7'd5;
    localparam logic [6:0] DST_JNZ  = 7'd6;
    localparam logic [6:0] DST_MEM  = 7'd7;
    localparam logic [6:0] DST_CALL = 7'd8;
    localparam logic [6:0] DST_HALT = 7'd9;

    // Architectural state
    logic [0:0]          state, state_nx;
    logic [PC_WIDTH-1:0] pc, pc_nx;
    logic [WIDTH-1:0]    a, a_nx;
    logic [WIDTH-1:0]    b, b_nx;
    logic [WIDTH-1:0]    p, p_nx;
    logic [WIDTH-1:0]    lr, lr_nx;
    logic [PRE_W-1:0]    prefix, prefix_nx;

    // Instruction fields
    logic       fmt;
    logic [6:0] dest;
    logic [7:0] src8;

    assign fmt  = pm_data_in[15];
    assign dest = pm_data_in[14:8];
    assign src8 = pm_data_in[7:0];

    // Immediate operand. Its low PRE_W bits are also the shifted prefix.
    logic [WIDTH-1:0] imm;
    assign imm = {prefix, src8};

    logic [PC_WIDTH-1:0] pc_inc;
    assign pc_inc = pc + PC_WIDTH'(1);

    // Source value mux
    logic [WIDTH-1:0] src_val;
    always_comb begin
        src_val = '0;
        if (!fmt) begin
            src_val = imm;
        end else begin
            unique case (src8)
                SRC_ZERO: src_val = '0;
                SRC_A:    src_val = a;
                SRC_B:    src_val = b;
                SRC_P:    src_val = p;
                SRC_PC:   src_val = WIDTH'(pc);
                SRC_ADD:  src_val = a + b;
                SRC_SUB:  src_val = a - b;
                SRC_AND:  src_val = a & b;
                SRC_OR:   src_val = a | b;
                SRC_XOR:  src_val = a ^ b;
                SRC_LT:   src_val = WIDTH'(a <  b);
                SRC_LE:   src_val = WIDTH'(a <= b);
                SRC_EQ:   src_val = WIDTH'(a == b);
                SRC_GE:   src_val = WIDTH'(a >= b);
                SRC_GT:   src_val = WIDTH'(a >  b);
                SRC_MEM:  src_val = dm_rdata;
                SRC_LR:   src_val = lr;
`ifdef TTA_CPU_SHIFT_OPS_EN
                SRC_SHL:  src_val = a << b[SH_W-1:0];
                SRC_SHR:  src_val = a >> b[SH_W-1:0];
                SRC_SAR:  src_val = $unsigned($signed(a) >>> b[SH_W-1:0]);
`endif
                default:  src_val = '0;
            endcase
        end
    end

    // A load that would store straight back to memory is a no-op with no request
    logic mem_nop;
    logic is_load;
    logic is_store;
    logic run;
    logic stall;
    logic advance;

    assign mem_nop  = fmt && (src8 == SRC_MEM) && (dest == DST_MEM);
    assign is_load  = fmt && (src8 == SRC_MEM) && !mem_nop;
    assign is_store = (dest == DST_MEM) && !mem_nop;
    assign run      = (state == ST_RUN);

    assign dm_req     = run && !reset && (is_load || is_store);
    assign dm_we      = dm_req && is_store;
    assign dm_address = p;
    assign dm_wdata   = dm_we ? src_val : '0;

    // Waiting on the data memory freezes every piece of state
    assign stall   = dm_req && !dm_ready;
    assign advance = run && !stall;

    assign pm_address = pc;
    assign halted     = (state == ST_HALT);

    logic [PC_WIDTH-1:0] target;
    assign target = PC_WIDTH'(src_val);

    // Next-state and execute logic
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        a_nx      = a;
        b_nx      = b;
        p_nx      = p;
        lr_nx     = lr;
        prefix_nx = prefix;

        if (advance) begin
            pc_nx     = pc_inc;
            prefix_nx = '0;
            if (!fmt && (dest == DST_PFX)) begin
                prefix_nx = imm[PRE_W-1:0];
            end
            unique case (dest)
                DST_A:    a_nx = src_val;
                DST_B:    b_nx = src_val;
                DST_P:    p_nx = src_val;
                DST_JMP:  pc_nx = target;
                DST_JZ:   if (a == '0) pc_nx = target;
                DST_JNZ:  if (a != '0) pc_nx = target;
                DST_CALL: begin
                    lr_nx = WIDTH'(pc_inc);
                    pc_nx = target;
                end
                DST_HALT: begin
                    state_nx = ST_HALT;
                    pc_nx    = pc;
                end
                default:  ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_RUN;
            pc     <= RESET_VECTOR;
            a      <= '0;
            b      <= '0;
            p      <= '0;
            lr     <= '0;
            prefix <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            a      <= a_nx;
            b      <= b_nx;
            p      <= p_nx;
            lr     <= lr_nx;
            prefix <= prefix_nx;
        end
    end

endmodule

// File: tb/tb_tta_cpu.sv
// tb_tta_cpu: self-checking bench for tta_cpu. A 16-bit core (reset vector
// 0x0100) runs a program assembled from a vector table and hand-written
// sequences. A 32-bit core runs a short prefix program. Stores are checked by a
// scoreboard fed while the programs are assembled.
module tb_tta_cpu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic reset32;

    // 16-bit core
    logic [15:0] pm_address, pm_data_in;
    logic        dm_req, dm_we, dm_ready, halted;
    logic [15:0] dm_address, dm_wdata, dm_rdata;
    logic [15:0] prog [0:1023];
    assign pm_data_in = prog[pm_address[9:0]];

    tta_cpu #(.WIDTH(16), .PC_WIDTH(16), .RESET_VECTOR(16'h0100)) u16 (
        .clock(clock), .reset(reset),
        .pm_address(pm_address), .pm_data_in(pm_data_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_address(dm_address),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .halted(halted)
    );

    // 32-bit core
    logic [15:0] pm_address32, pm_data32;
    logic        dm_req32, dm_we32, dm_ready32, halted32;
    logic [31:0] dm_address32, dm_wdata32, dm_rdata32;
    logic [15:0] prog32 [0:15];
    assign pm_data32 = prog32[pm_address32[3:0]];

    tta_cpu #(.WIDTH(32), .PC_WIDTH(16), .RESET_VECTOR(16'h0000)) u32 (
        .clock(clock), .reset(reset32),
        .pm_address(pm_address32), .pm_data_in(pm_data32),
        .dm_req(dm_req32), .dm_we(dm_we32), .dm_address(dm_address32),
        .dm_wdata(dm_wdata32), .dm_rdata(dm_rdata32), .dm_ready(dm_ready32),
        .halted(halted32)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        string       name;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  src;
        logic [15:0] expv;
        string       name;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    int unsigned ptr;

    function automatic logic [15:0] ins(input logic f, input logic [6:0] d, input logic [7:0] s);
        return {f, d, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic emit(input logic [15:0] w);
        prog[ptr[9:0]] = w;
        ptr++;
    endtask

    // Two-move load of a 16-bit constant through the prefix register
    task automatic load_reg(input logic [6:0] d, input logic [15:0] v);
        emit(ins(1'b0, 7'd0, v[15:8]));
        emit(ins(1'b0, d, v[7:0]));
    endtask

    task automatic expect16(input string name, input logic [15:0] d, input logic [15:0] ad);
        exp_t e;
        e.data = 32'(d);
        e.addr = 32'(ad);
        e.name = name;
        q16.push_back(e);
    endtask

    // Advance until the core fetches the given address, within a cycle budget
    task automatic wait_pc(input string name, input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (pm_address !== target && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, 32'(pm_address), 32'(target));
    endtask

    // Scoreboard monitors: a store completes when req & ready are seen mid-cycle
    always @(negedge clock) begin
        if (!reset && dm_req && dm_ready && dm_we) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_store16: got data %h at %h, expected no store", dm_wdata, dm_address);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check({e.name, "_data"}, 32'(dm_wdata), e.data);
                check({e.name, "_addr"}, 32'(dm_address), e.addr);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset32 && dm_req32 && dm_ready32 && dm_we32) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_store32: got data %h at %h, expected no store", dm_wdata32, dm_address32);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check({e.name, "_data"}, dm_wdata32, e.data);
                check({e.name, "_addr"}, dm_address32, e.addr);
            end
        end
    end

    initial begin
        logic [15:0] t;
        logic [15:0] s_addr;
        logic [15:0] l_addr;
        logic [15:0] e_shl, e_shr, e_sar;
        exp_t        e;

`ifdef TTA_CPU_SHIFT_OPS_EN
        e_shl = 16'h0010;
        e_shr = 16'h0800;
        e_sar = 16'hF800;
`else
        e_shl = 16'h0000;
        e_shr = 16'h0000;
        e_sar = 16'h0000;
`endif

        // ALU / source vectors: a, b, source code, expected store value
        vt[0]  = '{16'h0005, 16'h0007, 8'd6,  16'hFFFE, "sub"};
        vt[1]  = '{16'h0005, 16'h0007, 8'd10, 16'h0001, "lt"};
        vt[2]  = '{16'h0005, 16'h0007, 8'd5,  16'h000C, "add"};
        vt[3]  = '{16'hFFFF, 16'h0001, 8'd5,  16'h0000, "add_wrap"};
        vt[4]  = '{16'hF0F0, 16'hFF00, 8'd7,  16'hF000, "and"};
        vt[5]  = '{16'hF0F0, 16'hFF00, 8'd8,  16'hFFF0, "or"};
        vt[6]  = '{16'hF0F0, 16'hFF00, 8'd9,  16'h0FF0, "xor"};
        vt[7]  = '{16'h0007, 16'h0007, 8'd11, 16'h0001, "le_eq"};
        vt[8]  = '{16'h0007, 16'h0007, 8'd12, 16'h0001, "eq"};
        vt[9]  = '{16'h0007, 16'h0007, 8'd13, 16'h0001, "ge_eq"};
        vt[10] = '{16'h0007, 16'h0007, 8'd14, 16'h0000, "gt_eq"};
        vt[11] = '{16'h0009, 16'h0003, 8'd14, 16'h0001, "gt"};
        vt[12] = '{16'h0009, 16'h0003, 8'd10, 16'h0000, "lt_false"};
        vt[13] = '{16'h8000, 16'h7FFF, 8'd14, 16'h0001, "gt_unsigned"};
        vt[14] = '{16'h1234, 16'h5678, 8'd0,  16'h0000, "src_zero"};
        vt[15] = '{16'h1234, 16'h5678, 8'd1,  16'h1234, "src_a"};
        vt[16] = '{16'h1234, 16'h5678, 8'd2,  16'h5678, "src_b"};
        vt[17] = '{16'h1234, 16'h5678, 8'd3,  16'h0020, "src_p"};
        vt[18] = '{16'h8001, 16'h0004, 8'd17, e_shl,    "shl"};
        vt[19] = '{16'h8001, 16'h0004, 8'd18, e_shr,    "shr"};
        vt[20] = '{16'h8001, 16'h0004, 8'd19, e_sar,    "sar"};
        vt[21] = '{16'h8001, 16'h0004, 8'd20, 16'h0000, "unused_src"};
        vt[22] = '{16'h8001, 16'h0004, 8'd12, 16'h0000, "eq_false"};

        // Unused program memory halts, so a wrong-path jump stalls progress
        for (int i = 0; i < 1024; i++) prog[i] = ins(1'b1, 7'd9, 8'd0);
        for (int i = 0; i < 16; i++) prog32[i] = ins(1'b1, 7'd9, 8'd0);

        // Wrong-path landing pad for the untaken conditional jumps
        ptr = 32'h3F0;
        emit(ins(1'b0, 7'd0, 8'h0B));
        emit(ins(1'b0, 7'd7, 8'hAD));

        // Main program at the reset vector
        ptr = 32'h100;
        emit(ins(1'b1, 7'd7, 8'd4));
        expect16("first_store", 16'h0100, 16'h0000);
        emit(ins(1'b0, 7'd3, 8'h20));
        for (int i = 0; i < NV; i++) begin
            load_reg(7'd1, vt[i].a);
            load_reg(7'd2, vt[i].b);
            emit(ins(1'b1, 7'd7, vt[i].src));
            expect16(vt[i].name, vt[i].expv, 16'h0020);
        end
        expect16("src_pc", 16'(ptr), 16'h0020);
        emit(ins(1'b1, 7'd7, 8'd4));

        // jz with a == 0: taken over a bad store
        emit(ins(1'b0, 7'd1, 8'h00));
        t = 16'(ptr + 4);
        emit(ins(1'b0, 7'd0, t[15:8]));
        emit(ins(1'b0, 7'd5, t[7:0]));
        emit(ins(1'b0, 7'd0, 8'h0B));
        emit(ins(1'b0, 7'd7, 8'hAD));
        load_reg(7'd7, 16'h600D);
        expect16("jz_taken", 16'h600D, 16'h0020);
        // jnz with a == 0: falls through
        emit(ins(1'b0, 7'd0, 8'h03));
        emit(ins(1'b0, 7'd6, 8'hF0));
        load_reg(7'd7, 16'h1234);
        expect16("jnz_not_taken", 16'h1234, 16'h0020);
        // jnz with a == 1: taken over a bad store
        emit(ins(1'b0, 7'd1, 8'h01));
        t = 16'(ptr + 4);
        emit(ins(1'b0, 7'd0, t[15:8]));
        emit(ins(1'b0, 7'd6, t[7:0]));
        emit(ins(1'b0, 7'd0, 8'h0B));
        emit(ins(1'b0, 7'd7, 8'hAD));
        load_reg(7'd7, 16'h600E);
        expect16("jnz_taken", 16'h600E, 16'h0020);
        // jz with a == 1: falls through
        emit(ins(1'b0, 7'd0, 8'h03));
        emit(ins(1'b0, 7'd5, 8'hF0));
        load_reg(7'd7, 16'h5A5A);
        expect16("jz_not_taken", 16'h5A5A, 16'h0020);

        // Stalled store, then a zero-wait load into b
        load_reg(7'd1, 16'hBEEF);
        s_addr = 16'(ptr);
        emit(ins(1'b1, 7'd7, 8'd1));
        expect16("stall_store", 16'hBEEF, 16'h0020);
        l_addr = 16'(ptr);
        emit(ins(1'b1, 7'd2, 8'd15));
        emit(ins(1'b1, 7'd7, 8'd2));
        expect16("load_b", 16'hA5A5, 16'h0020);
        emit(ins(1'b0, 7'd4, 8'h10));

        // Call from 0x0010 to 0x0040, then report lr and pc and halt
        prog[16'h0010] = ins(1'b0, 7'd8, 8'h40);
        prog[16'h0040] = ins(1'b1, 7'd7, 8'd16);
        prog[16'h0041] = ins(1'b1, 7'd7, 8'd4);
        prog[16'h0042] = ins(1'b1, 7'd9, 8'd0);
        expect16("lr_after_call", 16'h0011, 16'h0020);
        expect16("pc_after_call", 16'h0041, 16'h0020);

        // 32-bit prefix program
        prog32[0] = ins(1'b0, 7'd0, 8'h12);
        prog32[1] = ins(1'b0, 7'd0, 8'h34);
        prog32[2] = ins(1'b0, 7'd0, 8'h56);
        prog32[3] = ins(1'b0, 7'd1, 8'h78);
        prog32[4] = ins(1'b1, 7'd7, 8'd1);
        prog32[5] = ins(1'b0, 7'd7, 8'h9A);
        prog32[6] = ins(1'b1, 7'd9, 8'd0);
        e = '{32'h12345678, 32'h0, "w32_prefix"};
        q32.push_back(e);
        e = '{32'h0000009A, 32'h0, "w32_prefix_cleared"};
        q32.push_back(e);

        // Reset state
        reset      = 1'b1;
        reset32    = 1'b1;
        dm_ready   = 1'b1;
        dm_rdata   = 16'h0000;
        dm_ready32 = 1'b1;
        dm_rdata32 = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", 32'(pm_address), 32'h0100);
        check("rst_req", 32'(dm_req), 32'h0);
        check("rst_we", 32'(dm_we), 32'h0);
        check("rst_wdata", 32'(dm_wdata), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);

        // First instruction stalls; reset mid-stall abandons the transaction
        reset    = 1'b0;
        dm_ready = 1'b0;
        #1;
        check("stall0_req", 32'(dm_req), 32'h1);
        check("stall0_we", 32'(dm_we), 32'h1);
        check("stall0_wdata", 32'(dm_wdata), 32'h0100);
        @(posedge clock); #1;
        check("stall0_pc_hold", 32'(pm_address), 32'h0100);
        reset = 1'b1;
        #1;
        check("rst_in_stall_req", 32'(dm_req), 32'h0);
        check("rst_in_stall_wdata", 32'(dm_wdata), 32'h0);
        @(posedge clock); #1;
        check("rst_in_stall_pc", 32'(pm_address), 32'h0100);
        reset    = 1'b0;
        reset32  = 1'b0;
        dm_ready = 1'b1;
        @(posedge clock); #1;
        check("first_exec_pc", 32'(pm_address), 32'h0101);

        // Store held for three wait cycles, completing on the fourth
        wait_pc("reach_stall_store", s_addr, 400);
        dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dm_ready = 1'b1;
            #1;
            check("stall_req", 32'(dm_req), 32'h1);
            check("stall_we", 32'(dm_we), 32'h1);
            check("stall_addr", 32'(dm_address), 32'h0020);
            check("stall_wdata", 32'(dm_wdata), 32'hBEEF);
            check("stall_pc", 32'(pm_address), 32'(s_addr));
            @(posedge clock); #1;
        end
        check("stall_pc_once", 32'(pm_address), 32'(s_addr + 16'd1));

        // Zero-wait load
        wait_pc("reach_load", l_addr, 10);
        dm_rdata = 16'hA5A5;
        #1;
        check("load_req", 32'(dm_req), 32'h1);
        check("load_we", 32'(dm_we), 32'h0);
        check("load_wdata", 32'(dm_wdata), 32'h0);
        @(posedge clock); #1;
        check("load_one_cycle", 32'(pm_address), 32'(l_addr + 16'd1));
        dm_rdata = 16'h0000;

        // Halt after the call
        wait_pc("reach_halt", 16'h0042, 50);
        check("halt_not_yet", 32'(halted), 32'h0);
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            check("halted", 32'(halted), 32'h1);
            check("halt_pc_frozen", 32'(pm_address), 32'h0042);
            check("halt_req", 32'(dm_req), 32'h0);
            check("halt_wdata", 32'(dm_wdata), 32'h0);
            @(posedge clock); #1;
        end
        check("w32_halted", 32'(halted32), 32'h1);
        check("w32_halt_pc", 32'(pm_address32), 32'h0006);

        // Reset leaves HALT
        reset = 1'b1;
        @(posedge clock); #1;
        check("rerst_halted", 32'(halted), 32'h0);
        check("rerst_pc", 32'(pm_address), 32'h0100);
        check("rerst_req", 32'(dm_req), 32'h0);

        check("q16_drained", 32'(q16.size()), 32'h0);
        check("q32_drained", 32'(q32.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tta_cpu.md
Name: tta_cpu

Overview:
- Parametrised transport-triggered CPU; next generation of the 16-bit move-machine core.
- Every instruction is one move: source -> destination.
- Adds:
  - configurable data and PC width
  - multi-byte constant prefixing
  - pointer-based data-memory load/store with a valid/ready handshake
  - link register for calls
  - halt state
- Sits between a combinational-read program memory and a handshaked data memory/bus.

Parameters:
- WIDTH, 16, data register/ALU width; multiple of 8, >= 16
- PC_WIDTH, 16, program counter and pm_address width
- RESET_VECTOR, 0, PC value loaded at reset

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pm_address  out  PC_WIDTH  instruction fetch address; always equals pc
- pm_data_in  in  16  instruction word; combinational read, valid in the same cycle
- dm_req  out  1  data-memory transaction request
- dm_we  out  1  1 = store, 0 = load; valid while dm_req=1
- dm_address  out  WIDTH  equals p
- dm_wdata  out  WIDTH  store data
- dm_rdata  in  WIDTH  load data, sampled when dm_req & dm_ready
- dm_ready  in  1  transaction completes on a rising edge where dm_req & dm_ready
- halted  out  1  core stopped

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous and active-high on `reset`.
- Instruction fields:
  - [15] = format
  - [14:8] = dest (7 bits)
  - [7:0] = src8
  - Format 0: source value = {prefix, src8}, prefix is WIDTH-8 bits.
  - Format 1: src8 selects a source.
- Sources (format 1):
  - 0: zero; 1: a; 2: b; 3: p; 4: pc (zero-extended)
  - 5: a+b; 6: a-b (both mod 2^WIDTH)
  - 7: a&b; 8: a|b; 9: a^b
  - 10: a<b; 11: a<=b; 12: a==b; 13: a>=b; 14: a>b. Compares are unsigned; result is 1 or 0, zero-extended.
  - 15: mem[p] (load)
  - 16: lr
  - Other codes: 0.
- Destinations:
  - 0: format 0 -> prefix <= {prefix[WIDTH-17:0], src8} (for WIDTH=16 this is prefix <= src8); format 1 -> NOP
  - 1: a; 2: b; 3: p
  - 4: pc <= value (jump)
  - 5: jump if a==0; 6: jump if a!=0
  - 7: mem[p] <= value (store)
  - 8: call: lr <= pc+1, pc <= value
  - 9: halt
  - 10..127: NOP
- Jump values are truncated to PC_WIDTH.
- PC: pc <= pc+1 (wraps at 2^PC_WIDTH) after every completed non-jump instruction and after untaken conditional jumps.
- Prefix: cleared to 0 on completion of any instruction other than a format-0 dest-0 move. Held during stalls.
- Memory handshake:
  - dm_req is combinational. It is 1 when state=RUN, reset=0 and the current instruction is a load (format 1, src 15) or a store (dest 7).
  - dm_we=1 for a store; dm_wdata = source value.
  - While dm_req=1 and dm_ready=0: no architectural state changes; pc, prefix and the instruction are held (stall).
  - dm_ready=1 in the same cycle completes the instruction with zero wait.
  - Load result is written to the destination on completion.
  - dest 7 with src 15 (format 1): NOP, no dm_req.
- FSM:
  - RUN: executes one instruction per cycle when not stalled.
  - HALT: entered on completion of dest 9; pc holds at the halt instruction, no further state changes, dm_req=0, halted=1. Only reset exits HALT.
- Reset values:
  - pc = RESET_VECTOR; a = b = p = lr = prefix = 0; state = RUN; halted = 0.
  - dm_req = dm_we = 0 while reset=1.
  - dm_wdata = 0 while reset=1 or dm_req=0.
  - Reset during a stall abandons the transaction; dm_req drops in the reset cycle.
- Simultaneous events: a conditional jump evaluates a as it was before the edge. The call's lr write and pc write occur on the same edge.

Optional Feature:
- Macro TTA_CPU_SHIFT_OPS_EN.
- Defined: sources 17 = a << b[log2(WIDTH)-1:0], 18 = a >> b[...] (logical), 19 = a >>> b[...] (arithmetic).
- Undefined: sources 17-19 return 0, like other unused codes.

Test Plan:
- Reset with RESET_VECTOR=0x0100 -> pm_address=0x0100, a=b=p=lr=0, halted=0, dm_req=0; first instruction executes on the next edge.
- WIDTH=32: prefix 0x12, prefix 0x34, prefix 0x56, then format 0 dest 1 src 0x78 -> a=0x12345678; prefix is 0 afterwards.
- a=5, b=7:
  - src 6 -> a = 0xFFFE (WIDTH=16)
  - src 10 -> 1
  - dest 5 with a=0 -> jump taken
  - dest 6 with a=0 -> pc+1
- p=0x20: store a=0xBEEF with dm_ready low 3 cycles -> dm_req=1, dm_we=1, dm_address=0x20, dm_wdata=0xBEEF held 4 cycles; pc advances exactly once.
- Load src 15 -> dest 2 with dm_ready=1 immediately, dm_rdata=0xA5A5 -> b=0xA5A5 after 1 cycle.
- Call to 0x0040 from pc=0x0010 -> lr=0x0011, pc=0x0040; dest 9 -> halted=1, pc frozen; assert reset -> halted=0, pc=RESET_VECTOR.
